// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the 3DES control unit command stream:
// mode codes, sequencer states and default block geometry.
package des_ctrl_pkg;

   localparam int unsigned KEY_BYTES_DEF = 24;
   localparam int unsigned BLK_BYTES_DEF = 8;

   // Command codes consumed by the control unit; 7 is reserved and never driven.
   typedef enum logic [2:0] {
      M_IDLE    = 3'd0,
      M_KEY_ENC = 3'd1,
      M_KEY_DEC = 3'd2,
      M_DAT_ENC = 3'd3,
      M_DAT_DEC = 3'd4,
      M_CLEAR   = 3'd5,
      M_UNLOAD  = 3'd6
   } mode_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      KEY,
      DATA,
      WAIT,
      UNLOAD,
      CLEAR_ABORT
   } state_t;

endpackage

// File: rtl/des_cmd_seq_if.sv
// Host-side byte handshake and job-request signals of the command sequencer.
interface des_cmd_seq_if;

   logic start;
   logic rekey;
   logic decrypt;
   logic in_valid;
   logic in_ready;
   logic core_done;
   logic out_valid;
   logic out_ready;

   modport master (
      output start, rekey, decrypt, in_valid, core_done, out_ready,
      input  in_ready, out_valid
   );

   modport slave (
      input  start, rekey, decrypt, in_valid, core_done, out_ready,
      output in_ready, out_valid
   );

endinterface

// File: rtl/des_cmd_seq.sv
// Job sequencer: turns host byte handshakes into clear/key/data/unload
// commands for the 3DES control unit, with a bounded wait for the core.
module des_cmd_seq
   import des_ctrl_pkg::*;
#(
   parameter int unsigned KEY_BYTES = KEY_BYTES_DEF,
   parameter int unsigned BLK_BYTES = BLK_BYTES_DEF,
   parameter int unsigned TIMEOUT   = 1023,
   localparam int unsigned CNT_W    = $clog2(KEY_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   des_cmd_seq_if.slave     host,
   output logic [2:0]       mode,
   output logic             busy,
   output logic             err_timeout,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt_n;
   logic [WAIT_W-1:0] wait_cnt, wait_n;
   logic              dec_q, dec_n;
   logic              keys_loaded, keys_n;
   logic              err_n;
   mode_t             mode_c;
   logic              in_ready_c;
   logic              out_valid_c;

   // State and counter registers; reset abandons any job without a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         wait_cnt    <= '0;
         dec_q       <= 1'b0;
         keys_loaded <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         byte_cnt    <= cnt_n;
         wait_cnt    <= wait_n;
         dec_q       <= dec_n;
         keys_loaded <= keys_n;
         err_timeout <= err_n;
      end
   end

   // Next state, counter updates and Mealy command outputs.
   always_comb begin
      state_n     = state;
      cnt_n       = byte_cnt;
      wait_n      = wait_cnt;
      dec_n       = dec_q;
      keys_n      = keys_loaded;
      err_n       = err_timeout;
      mode_c      = M_IDLE;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;

      case (state)
         IDLE: begin
            if (host.start) begin
               dec_n   = host.decrypt;
               err_n   = 1'b0;
               cnt_n   = '0;
               state_n = (host.rekey || !keys_loaded) ? CLEAR : DATA;
            end
         end

         CLEAR: begin
            mode_c  = M_CLEAR;
            keys_n  = 1'b0;
            cnt_n   = '0;
            state_n = KEY;
         end

         KEY: begin
            in_ready_c = 1'b1;
            if (host.in_valid) begin
               mode_c = dec_q ? M_KEY_DEC : M_KEY_ENC;
               if (byte_cnt == CNT_W'(KEY_BYTES - 1)) begin
                  keys_n  = 1'b1;
                  cnt_n   = '0;
                  state_n = DATA;
               end else begin
                  cnt_n = byte_cnt + CNT_W'(1);
               end
            end
         end

         DATA: begin
            in_ready_c = 1'b1;
            if (host.in_valid) begin
               mode_c = dec_q ? M_DAT_DEC : M_DAT_ENC;
               if (byte_cnt == CNT_W'(BLK_BYTES - 1)) begin
                  cnt_n   = '0;
                  wait_n  = '0;
                  state_n = WAIT;
               end else begin
                  cnt_n = byte_cnt + CNT_W'(1);
               end
            end
         end

         // Completion wins over an expiring timeout in the same cycle.
         WAIT: begin
            if (host.core_done) begin
               state_n = UNLOAD;
            end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
               err_n   = 1'b1;
               keys_n  = 1'b0;
               state_n = CLEAR_ABORT;
            end else begin
               wait_n = wait_cnt + WAIT_W'(1);
            end
         end

         UNLOAD: begin
            out_valid_c = 1'b1;
            if (host.out_ready) begin
               mode_c = M_UNLOAD;
               if (byte_cnt == CNT_W'(BLK_BYTES - 1)) begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = byte_cnt + CNT_W'(1);
               end
            end
         end

         CLEAR_ABORT: begin
            mode_c  = M_CLEAR;
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   assign mode           = mode_c;
   assign host.in_ready  = in_ready_c;
   assign host.out_valid = out_valid_c;
   assign busy           = (state != IDLE);

endmodule

// File: doc/des_cmd_seq.md
Name: des_cmd_seq

Overview:
- Host-side command initiator for the 3DES accelerator control unit. It converts byte-stream handshakes into the 3-bit mode command stream that the control unit consumes.
- For each job it issues, in order: an optional clear, 24 key-byte loads (encrypt or decrypt key schedule), 8 data-byte loads, a wait for core completion, and 8 result-byte unloads.
- Sits between the host byte interface and the control unit; it drives only control signals and never touches the datapath bytes.

Parameters:
KEY_BYTES, 24, key bytes loaded per rekey (three 8-byte DES keys)
BLK_BYTES, 8, data/result bytes per block
TIMEOUT, 1023, maximum WAIT cycles before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle job request; sampled only in IDLE
rekey  in  1  qualified by start: 1 = clear and reload keys first
decrypt  in  1  qualified by start: selects decrypt mode codes; latched for the job
in_valid  in  1  host has an input byte on the shared data bus
in_ready  out  1  sequencer accepts the byte this cycle
core_done  in  1  core result available (level or pulse)
out_valid  out  1  result byte present on the output bus this cycle
out_ready  in  1  host consumes the result byte
mode  out  3  command to control unit (combinational)
busy  out  1  state != IDLE
err_timeout  out  1  sticky; set when WAIT expires
byte_cnt  out  5  bytes handled in current phase

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, byte_cnt=0, wait_cnt=0, dec_q=0, err_timeout=0. Outputs: mode=0, in_ready=0, out_valid=0, busy=0. A reset in any state aborts the job immediately; no clear is issued.
- Mode codes (package constants): M_IDLE=0, M_KEY_ENC=1, M_KEY_DEC=2, M_DAT_ENC=3, M_DAT_DEC=4, M_CLEAR=5, M_UNLOAD=6. Value 7 is never driven.
- mode, in_ready and out_valid are Mealy outputs of the registered state. All fires (accept, drain, state change) take effect at the same clk edge; there is no pipeline latency.
- IDLE: mode=0. On start, latch dec_q=decrypt.
  - rekey=1 -> CLEAR.
  - rekey=0 and keys_loaded=1 -> DATA.
  - rekey=0 and keys_loaded=0 -> CLEAR (forced rekey).
- CLEAR: one cycle. mode=M_CLEAR, keys_loaded<=0, byte_cnt<=0, then -> KEY.
- KEY: in_ready=1. mode = (dec_q ? M_KEY_DEC : M_KEY_ENC) only when in_valid=1; otherwise mode=0.
  - Each accept increments byte_cnt.
  - The accept at byte_cnt==KEY_BYTES-1 sets keys_loaded=1, clears byte_cnt and moves to DATA.
- DATA: in_ready=1. mode = (dec_q ? M_DAT_DEC : M_DAT_ENC) on each accept, otherwise 0.
  - The accept at byte_cnt==BLK_BYTES-1 clears byte_cnt and wait_cnt and moves to WAIT.
- WAIT: mode=0, in_ready=0, wait_cnt increments each cycle.
  - core_done=1 -> UNLOAD. core_done has priority over timeout in the same cycle.
  - wait_cnt==TIMEOUT without done -> set err_timeout, keys_loaded<=0, -> CLEAR_ABORT.
- CLEAR_ABORT: one cycle with mode=M_CLEAR, then -> IDLE.
- UNLOAD: out_valid=1. mode=M_UNLOAD only when out_ready=1, so each command equals exactly one consumed byte and the control unit's count decrements once per drain. out_ready=0 stalls with mode=0.
  - The drain at byte_cnt==BLK_BYTES-1 clears byte_cnt and moves to IDLE.
- start outside IDLE is ignored. rekey and decrypt are ignored except when qualified by start in IDLE.
- err_timeout clears only on reset or on the next accepted start.
- byte_cnt never exceeds KEY_BYTES-1 and never wraps; width is $clog2(KEY_BYTES+1).
- keys_loaded is an internal register, reset to 0.

Decomposition:
- Package des_ctrl_pkg holds:
  - mode_t (3-bit enum) carrying the mode codes above, shared with the control unit;
  - state enum {IDLE, CLEAR, KEY, DATA, WAIT, UNLOAD, CLEAR_ABORT};
  - constants KEY_BYTES_DEF=24 and BLK_BYTES_DEF=8.
- Single module, no sub-module. The counters are inline.

Test Plan:
- start, rekey=1, decrypt=0, in_valid held high -> 1 cycle mode=5, then 24 cycles mode=1, then 8 cycles mode=3, then WAIT with mode=0. byte_cnt reads 23 on the last key beat.
- Same job with decrypt=1, in_valid toggling every other cycle -> mode=2/4 only on valid cycles. Exactly 24 key and 8 data commands; total key phase is 48 cycles.
- Second start with rekey=0 after a completed job -> no mode=5 and no key commands; goes directly to 8 mode=3 cycles.
- core_done after 5 WAIT cycles, out_ready pattern 1,0,0,1,... -> exactly 8 mode=6 cycles, each coinciding with out_ready=1. Returns to IDLE and busy=0 the cycle after the 8th drain.
- No core_done, TIMEOUT=15 -> after 16 WAIT cycles err_timeout=1, then one mode=5 cycle, then IDLE. A following start with rekey=0 is forced through CLEAR and KEY.
- rst=1 asserted in the middle of KEY (byte_cnt=10) -> next cycle mode=0, busy=0, byte_cnt=0. A subsequent start with rekey=0 performs a full rekey.
